pwm_ramp_ctrl: RTL and testbench

- Frame scheduler and configuration controller for a bank of NCH pwm channels sharing one clock.
- Owns the frame counter and the shadowed period, and accepts per-channel target-uptime commands over a valid/ready port.
- Steps each channel's live uptime toward its target by a programmable step once per frame, so duty changes are glitch-free and slew-limited (servo/motor soft start).
- Drives the period/uptime inputs of the pwm instances and tells downstream logic where frame boundaries fall.

---
 rtl/pwm_ramp_ctrl.sv | 127 ++++++++++++
 tb/tb_pwm_ramp_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_ramp_ctrl.sv
// rtl/pwm_ramp_ctrl.sv - frame scheduler and slew-limited uptime controller for NCH pwm channels
// Optional PWM_RAMP_CLAMP_EN: clamps each effective target to pwm_period+1.
module pwm_ramp_ctrl #(
  parameter int NCH = 4,
  parameter int W   = 21,
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [W-1:0]     cfg_period,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CW-1:0]    cmd_ch,
  input  logic [W-1:0]     cmd_uptime,
  input  logic [W-1:0]     cmd_step,
  output logic [W-1:0]     pwm_period,
  output logic [NCH*W-1:0] pwm_uptime,
  output logic [W-1:0]     frame_cnt,
  output logic             frame_end,
  output logic [NCH-1:0]   at_target,
  output logic             running
);

  typedef enum logic [1:0] {OFF, RUN, DRAIN} state_t;

  state_t       state;
  logic [W-1:0] period_q;
  logic [W-1:0] cnt_q;
  logic [W-1:0] live_q  [NCH];
  logic [W-1:0] tgt_q   [NCH];
  logic [W-1:0] step_q  [NCH];
  logic [W-1:0] bnd_tgt [NCH];
  logic [W-1:0] cmp_tgt [NCH];
  logic         cmd_fire;

  // One slew step toward tgt; the step saturates at tgt so nothing can wrap.
  function automatic logic [W-1:0] ramp(input logic [W-1:0] cur,
                                        input logic [W-1:0] tgt,
                                        input logic [W-1:0] stp);
    if (stp == '0 || cur == tgt) return tgt;
    if (cur < tgt) return (stp >= tgt - cur) ? tgt : cur + stp;
    return (stp >= cur - tgt) ? tgt : cur - stp;
  endfunction

`ifdef PWM_RAMP_CLAMP_EN
  function automatic logic [W-1:0] clamp(input logic [W-1:0] tgt,
                                         input logic [W-1:0] per);
    logic [W:0] lim;
    lim = {1'b0, per} + 1'b1;
    return ({1'b0, tgt} > lim) ? lim[W-1:0] : tgt;
  endfunction
`endif

  // Boundary updates clamp against the period being loaded; at_target against the active one.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
`ifdef PWM_RAMP_CLAMP_EN
      bnd_tgt[i] = clamp(tgt_q[i], cfg_period);
      cmp_tgt[i] = clamp(tgt_q[i], period_q);
`else
      bnd_tgt[i] = tgt_q[i];
      cmp_tgt[i] = tgt_q[i];
`endif
    end
  end

  assign running   = (state == RUN) || (state == DRAIN);
  assign frame_end = running && (cnt_q >= period_q);
  assign cmd_ready = !rst && ((state == OFF) || (state == RUN));
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign frame_cnt = cnt_q;
  assign pwm_period = period_q;

  always_comb begin
    pwm_uptime = '0;
    at_target  = '0;
    for (int i = 0; i < NCH; i++) begin
      if (state != OFF) pwm_uptime[i*W +: W] = live_q[i];
      at_target[i] = (live_q[i] == cmp_tgt[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= OFF;
      cnt_q    <= '0;
      period_q <= '0;
      for (int i = 0; i < NCH; i++) begin
        live_q[i] <= '0;
        tgt_q[i]  <= '0;
        step_q[i] <= '0;
      end
    end else begin
      // Channel indices >= NCH match no slot and are dropped.
      for (int i = 0; i < NCH; i++) begin
        if (cmd_fire && cmd_ch == CW'(i)) begin
          tgt_q[i]  <= cmd_uptime;
          step_q[i] <= cmd_step;
        end
      end
      case (state)
        OFF: begin
          cnt_q <= '0;
          if (en) begin
            period_q <= cfg_period;
            state    <= RUN;
          end
        end
        RUN, DRAIN: begin
          cnt_q <= frame_end ? '0 : cnt_q + 1'b1;
          if (frame_end) begin
            period_q <= cfg_period;
            for (int i = 0; i < NCH; i++)
              live_q[i] <= (state == DRAIN && !en) ? '0
                         : ramp(live_q[i], bnd_tgt[i], step_q[i]);
          end
          if (en)                 state <= RUN;
          else if (state == RUN)  state <= DRAIN;
          else if (frame_end)     state <= OFF;
        end
        default: state <= OFF;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// tb/tb_pwm_ramp_ctrl.sv - directed and randomized checks of pwm_ramp_ctrl against a frame-level model
module tb_pwm_ramp_ctrl;
  localparam int NCH = 4;
  localparam int W   = 21;
  localparam int CW  = $clog2(NCH);
`ifdef PWM_RAMP_CLAMP_EN
  localparam bit CLAMP = 1'b1;
`else
  localparam bit CLAMP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst, en, cmd_valid, cmd_ready, frame_end, running;
  logic [W-1:0]     cfg_period, cmd_uptime, cmd_step, pwm_period, frame_cnt;
  logic [CW-1:0]    cmd_ch;
  logic [NCH*W-1:0] pwm_uptime;
  logic [NCH-1:0]   at_target;

  int n_chk = 0;
  int n_fail = 0;
  int m_live [NCH];
  int m_tgt  [NCH];
  int m_step [NCH];
  int m_period;

  pwm_ramp_ctrl #(.NCH(NCH), .W(W)) dut (
    .clk(clk), .rst(rst), .en(en), .cfg_period(cfg_period),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ch(cmd_ch),
    .cmd_uptime(cmd_uptime), .cmd_step(cmd_step), .pwm_period(pwm_period),
    .pwm_uptime(pwm_uptime), .frame_cnt(frame_cnt), .frame_end(frame_end),
    .at_target(at_target), .running(running)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int eff(input int tgt, input int per);
    return (CLAMP && tgt > per + 1) ? per + 1 : tgt;
  endfunction

  function automatic int next_live(input int cur, input int tgt, input int stp);
    if (stp == 0) return tgt;
    if (cur < tgt) return (cur + stp > tgt) ? tgt : cur + stp;
    if (cur > tgt) return (cur - stp < tgt) ? tgt : cur - stp;
    return cur;
  endfunction

  task automatic model_boundary();
    for (int i = 0; i < NCH; i++)
      m_live[i] = next_live(m_live[i], eff(m_tgt[i], int'(cfg_period)), m_step[i]);
    m_period = int'(cfg_period);
  endtask

  task automatic check_all(input string tag);
    logic [NCH-1:0] exp_at;
    chk({tag, "_period"}, pwm_period, m_period);
    for (int i = 0; i < NCH; i++) begin
      chk($sformatf("%s_live%0d", tag, i), pwm_uptime[i*W +: W], m_live[i]);
      exp_at[i] = (m_live[i] == eff(m_tgt[i], m_period));
    end
    chk({tag, "_at_target"}, at_target, exp_at);
  endtask

  task automatic wait_fe();
    int k = 0;
    while (frame_end !== 1'b1 && k < 5000) begin
      tick();
      k++;
    end
    chk("frame_end_timeout", frame_end, 1);
  endtask

  task automatic boundary(input string tag);
    wait_fe();
    model_boundary();
    tick();
    chk({tag, "_cnt0"}, frame_cnt, 0);
    check_all(tag);
  endtask

  task automatic send_cmd(input int ch, input int up, input int st);
    cmd_valid = 1'b1;
    cmd_ch = CW'(ch);
    cmd_uptime = W'(up);
    cmd_step = W'(st);
    chk("cmd_ready_accept", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    m_tgt[ch] = up;
    m_step[ch] = st;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_live[i] = 0;
      m_tgt[i] = 0;
      m_step[i] = 0;
    end
    m_period = 0;
  endtask

  initial begin
    int k;
    rst = 1'b1; en = 1'b0; cfg_period = '0; cmd_valid = 1'b0;
    cmd_ch = '0; cmd_uptime = '0; cmd_step = '0;
    model_reset();
    tick(); tick();
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_period", pwm_period, 0);
    chk("rst_uptime", pwm_uptime, 0);
    chk("rst_frame_end", frame_end, 0);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_running", running, 0);
    chk("rst_at_target", at_target, {NCH{1'b1}});
    rst = 1'b0;
    tick();
    chk("off_cmd_ready", cmd_ready, 1);

    // Preload in OFF, then start with a 2000-cycle frame.
    send_cmd(0, 1500, 500);
    send_cmd(1, 1000, 0);
    chk("preload_not_at_target0", at_target[0], 0);
    chk("off_uptime_zero", pwm_uptime, 0);
    cfg_period = 1999; en = 1'b1;
    tick();
    m_period = 1999;
    chk("run_running", running, 1);
    chk("run_period", pwm_period, 1999);
    chk("run_cnt_start", frame_cnt, 0);
    repeat (1998) tick();
    chk("pre_end_cnt", frame_cnt, 1998);
    chk("pre_end_fe", frame_end, 0);
    chk("pre_end_uptime", pwm_uptime, 0);
    tick();
    chk("first_fe_cnt", frame_cnt, 1999);
    chk("first_fe", frame_end, 1);
    boundary("f1");
    chk("f1_ch0", pwm_uptime[0*W +: W], 500);
    chk("f1_ch1", pwm_uptime[1*W +: W], 1000);
    k = 0;
    while (frame_end !== 1'b1 && k < 5000) begin tick(); k++; end
    chk("frame_len", k, 1999);
    boundary("f2");
    chk("f2_ch0", pwm_uptime[0*W +: W], 1000);
    boundary("f3");
    chk("f3_ch0", pwm_uptime[0*W +: W], 1500);
    chk("f3_at_target0", at_target[0], 1);

    // Period change is deferred to the boundary; ch1 slews down without underflow.
    cfg_period = 99;
    tick();
    chk("mid_frame_period", pwm_period, 1999);
    send_cmd(1, 100, 300);
    boundary("d1");
    chk("d1_ch1", pwm_uptime[1*W +: W], 700);
    boundary("d2");
    chk("d2_ch1", pwm_uptime[1*W +: W], 400);
    boundary("d3");
    chk("d3_ch1", pwm_uptime[1*W +: W], 100);
    boundary("d4");
    chk("d4_ch1", pwm_uptime[1*W +: W], 100);

    // Command on the frame_end cycle takes effect only at the following boundary.
    wait_fe();
    cmd_valid = 1'b1; cmd_ch = 2; cmd_uptime = 50; cmd_step = 0;
    model_boundary();
    tick();
    cmd_valid = 1'b0;
    m_tgt[2] = 50; m_step[2] = 0;
    check_all("coinc");
    chk("coinc_ch2_hold", pwm_uptime[2*W +: W], 0);
    boundary("coinc_next");
    chk("coinc_ch2_new", pwm_uptime[2*W +: W], 50);

    for (int r = 0; r < 10; r++) begin
      if ($urandom_range(1, 0) == 1)
        send_cmd($urandom_range(NCH - 1, 0), $urandom_range(150, 0), $urandom_range(60, 0));
      boundary($sformatf("rnd%0d", r));
    end

    // Drain: frame completes, then OFF with live cleared and targets kept.
    k = 0;
    while (frame_cnt != 10 && k < 500) begin tick(); k++; end
    chk("drain_sync", frame_cnt, 10);
    en = 1'b0;
    tick();
    chk("drain_running", running, 1);
    chk("drain_cmd_ready", cmd_ready, 0);
    k = 0;
    while (frame_cnt != 99 && k < 500) begin tick(); k++; end
    chk("drain_last_fe", frame_end, 1);
    chk("drain_last_running", running, 1);
    for (int i = 0; i < NCH; i++) m_live[i] = 0;
    m_period = int'(cfg_period);
    tick();
    chk("off_running", running, 0);
    chk("off_uptime", pwm_uptime, 0);
    chk("off_cnt", frame_cnt, 0);
    chk("off_ready", cmd_ready, 1);
    check_all("off");

    // Brief DRAIN then en returns: the frame keeps counting.
    en = 1'b1;
    tick();
    chk("rerun_cnt", frame_cnt, 0);
    repeat (5) tick();
    en = 1'b0;
    repeat (3) tick();
    chk("redrain_ready", cmd_ready, 0);
    en = 1'b1;
    tick();
    chk("rerun_running", running, 1);
    chk("rerun_frame_kept", frame_cnt, 9);
    chk("rerun_ready", cmd_ready, 1);
    boundary("rerun");

    // Reset mid-frame aborts with no drain.
    repeat (7) tick();
    rst = 1'b1;
    tick();
    model_reset();
    chk("mrst_cnt", frame_cnt, 0);
    chk("mrst_period", pwm_period, 0);
    chk("mrst_uptime", pwm_uptime, 0);
    chk("mrst_fe", frame_end, 0);
    chk("mrst_running", running, 0);
    chk("mrst_ready", cmd_ready, 0);
    chk("mrst_at_target", at_target, {NCH{1'b1}});
    rst = 1'b0;
    en = 1'b0;
    tick();

    // Target above period: clamped only when the option is built in.
    send_cmd(0, 500, 0);
    cfg_period = 99; en = 1'b1;
    tick();
    m_period = 99;
    boundary("clamp");
    chk("clamp_ch0", pwm_uptime[0*W +: W], CLAMP ? 100 : 500);

    // cfg_period=0: frame_end stays high and the ramp steps every cycle.
    send_cmd(3, 30, 10);
    cfg_period = 0;
    boundary("p0_enter");
    for (int r = 0; r < 4; r++) begin
      chk("p0_fe_high", frame_end, 1);
      boundary($sformatf("p0_%0d", r));
    end

    en = 1'b0;
    tick(); tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
